// File: rtl/regfile_pkg.sv
// regfile_pkg: shared writeback widths, request record and grant-source encoding.
// No ports; imported by the interface, the round-robin arbiter and the top.
package regfile_pkg;
    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int REG_ADDR_W = 5;
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: bundle of issue, busy-query, writeback-request and register-file write signals.
// master: issue/query/request producer side; slave: the arbiter (drives readies, busy flags, wb_*).
interface wb_arbiter_if #(
    parameter int XLEN = 64
);
    import regfile_pkg::*;
    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic                  rs1_busy;
    logic                  rs2_busy;
    logic                  alu_wb_valid;
    logic [REG_ADDR_W-1:0] alu_wb_addr;
    logic [XLEN-1:0]       alu_wb_data;
    logic                  alu_wb_ready;
    logic                  mem_wb_valid;
    logic [REG_ADDR_W-1:0] mem_wb_addr;
    logic [XLEN-1:0]       mem_wb_data;
    logic                  mem_wb_ready;
    logic                  wb_en;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic [XLEN-1:0]       wb_data;
    modport master (
        output issue_valid, issue_rd, rs1_addr, rs2_addr,
        output alu_wb_valid, alu_wb_addr, alu_wb_data,
        output mem_wb_valid, mem_wb_addr, mem_wb_data,
        input  rs1_busy, rs2_busy, alu_wb_ready, mem_wb_ready,
        input  wb_en, wb_addr, wb_data
    );
    modport slave (
        input  issue_valid, issue_rd, rs1_addr, rs2_addr,
        input  alu_wb_valid, alu_wb_addr, alu_wb_data,
        input  mem_wb_valid, mem_wb_addr, mem_wb_data,
        output rs1_busy, rs2_busy, alu_wb_ready, mem_wb_ready,
        output wb_en, wb_addr, wb_data
    );
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant, req[0]=ALU, req[1]=MEM.
// Ports: clk, reset (async, active-high), req[1:0], xfer (a grant was taken), gnt[1:0] (at most one high).
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       xfer,
    output logic [1:0] gnt
);
    src_t last_grant;
    // A lone request always wins; on a tie the source that lost last time goes first.
    always_comb begin
        gnt[0] = req[0] && (!req[1] || last_grant == SRC_MEM);
        gnt[1] = req[1] && (!req[0] || last_grant == SRC_ALU);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_grant <= SRC_MEM;
        else if (xfer)
            last_grant <= gnt[1] ? SRC_MEM : SRC_ALU;
    end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and load-unit writebacks onto one registered register-file write port
// and tracks pending writes in a busy scoreboard.
// Ports: clk, reset (async, active-high), bus (wb_arbiter_if.slave: issue, rs queries, two requests, wb port).
module wb_arbiter
    import regfile_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input logic         clk,
    input logic         reset,
    wb_arbiter_if.slave bus
);
    logic [1:0]            gnt;
    logic                  xfer;
    logic [REG_ADDR_W-1:0] sel_addr;
    logic [XLEN-1:0]       sel_data;
    logic [NREG-1:0]       busy;
    logic [NREG-1:0]       set_mask;
    logic [NREG-1:0]       clr_mask;
    // Requests are masked during reset so neither ready can rise.
    rr_arbiter2 u_rr (
        .clk   (clk),
        .reset (reset),
        .req   ({bus.mem_wb_valid, bus.alu_wb_valid} & {2{!reset}}),
        .xfer  (xfer),
        .gnt   (gnt)
    );
    assign xfer = |gnt;
    always_comb begin
        bus.alu_wb_ready = gnt[0];
        bus.mem_wb_ready = gnt[1];
        sel_addr = gnt[1] ? bus.mem_wb_addr : bus.alu_wb_addr;
        sel_data = gnt[1] ? bus.mem_wb_data : bus.alu_wb_data;
        set_mask = (bus.issue_valid && bus.issue_rd != '0) ? NREG'(1) << bus.issue_rd : '0;
        clr_mask = bus.wb_en ? NREG'(1) << bus.wb_addr : '0;
        bus.rs1_busy = busy[bus.rs1_addr];
        bus.rs2_busy = busy[bus.rs2_addr];
    end
    // Set is applied after clear so a new producer wins over the write it races with; x0 never busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            busy <= '0;
        else
            busy <= ((busy & ~clr_mask) | set_mask) & ~NREG'(1);
    end
    // Writes to x0 are accepted but never reach the register file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.wb_en   <= 1'b0;
            bus.wb_addr <= '0;
            bus.wb_data <= '0;
        end else begin
            bus.wb_en <= xfer && sel_addr != '0;
            if (xfer) begin
                bus.wb_addr <= sel_addr;
                bus.wb_data <= sel_data;
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: self-checking bench for wb_arbiter using per-cycle records and a writeback queue.
// No ports.
module tb_wb_arbiter;
    import regfile_pkg::*;
    typedef struct {
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        av;
        logic [4:0]  aa;
        logic [63:0] ad;
        logic        mv;
        logic [4:0]  ma;
        logic [63:0] md;
        logic        ea;
        logic        em;
    } cyc_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    wb_arbiter_if #(.XLEN(XLEN)) bus ();
    wb_arbiter #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    int errs = 0;
    int checks = 0;
    wb_req_t exp_q[$];
    wb_req_t cur;
    logic [NREG-1:0] mbusy;
    cyc_t tbl[11];
    function automatic cyc_t mk(input logic iv, input int ird, input int rs1, input int rs2,
                                input logic av, input int aa, input logic [63:0] ad,
                                input logic mv, input int ma, input logic [63:0] md,
                                input logic ea, input logic em);
        cyc_t c;
        c.iv = iv; c.ird = 5'(ird); c.rs1 = 5'(rs1); c.rs2 = 5'(rs2);
        c.av = av; c.aa = 5'(aa); c.ad = ad;
        c.mv = mv; c.ma = 5'(ma); c.md = md;
        c.ea = ea; c.em = em;
        return c;
    endfunction
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask
    // Called at a falling edge: drive one cycle, check combinational outputs, then check
    // the registered write that appears at the next falling edge.
    task automatic cyc(input cyc_t c);
        wb_req_t nxt;
        wb_req_t got;
        bus.issue_valid = c.iv; bus.issue_rd = c.ird;
        bus.rs1_addr = c.rs1; bus.rs2_addr = c.rs2;
        bus.alu_wb_valid = c.av; bus.alu_wb_addr = c.aa; bus.alu_wb_data = c.ad;
        bus.mem_wb_valid = c.mv; bus.mem_wb_addr = c.ma; bus.mem_wb_data = c.md;
        #1;
        chk("rs1_busy", bus.rs1_busy, mbusy[c.rs1]);
        chk("rs2_busy", bus.rs2_busy, mbusy[c.rs2]);
        chk("alu_ready", bus.alu_wb_ready, c.ea);
        chk("mem_ready", bus.mem_wb_ready, c.em);
        if (c.iv && c.ird != 0)
            assert (!mbusy[c.ird] || (cur.valid && cur.addr == c.ird))
            else $error("illegal issue to busy r%0d", c.ird);
        if (cur.valid) mbusy[cur.addr] = 1'b0;
        if (c.iv && c.ird != 0) mbusy[c.ird] = 1'b1;
        mbusy[0] = 1'b0;
        nxt = '0;
        if (c.ea) nxt = '{valid: c.aa != 0, addr: c.aa, data: c.ad};
        else if (c.em) nxt = '{valid: c.ma != 0, addr: c.ma, data: c.md};
        exp_q.push_back(nxt);
        @(negedge clk);
        got = exp_q.pop_front();
        chk("wb_en", bus.wb_en, got.valid);
        if (got.valid) begin
            chk("wb_addr", bus.wb_addr, got.addr);
            chk("wb_data", bus.wb_data, got.data);
        end
        cur = got;
    endtask
    task automatic do_reset();
        bus.issue_valid = 1'b0; bus.issue_rd = 5'd0;
        bus.rs1_addr = 5'd9; bus.rs2_addr = 5'd12;
        bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd4; bus.alu_wb_data = 64'h1;
        bus.mem_wb_valid = 1'b1; bus.mem_wb_addr = 5'd4; bus.mem_wb_data = 64'h2;
        reset = 1'b1;
        #1;
        chk("rst_wb_en", bus.wb_en, 0);
        chk("rst_wb_addr", bus.wb_addr, 0);
        chk("rst_wb_data", bus.wb_data, 0);
        chk("rst_alu_ready", bus.alu_wb_ready, 0);
        chk("rst_mem_ready", bus.mem_wb_ready, 0);
        chk("rst_rs1_busy", bus.rs1_busy, 0);
        chk("rst_rs2_busy", bus.rs2_busy, 0);
        @(negedge clk);
        chk("rst_hold_wb_en", bus.wb_en, 0);
        reset = 1'b0;
        mbusy = '0;
        cur = '0;
        exp_q.delete();
    endtask
    initial begin
        bus.issue_valid = 1'b0; bus.issue_rd = '0; bus.rs1_addr = '0; bus.rs2_addr = '0;
        bus.alu_wb_valid = 1'b0; bus.alu_wb_addr = '0; bus.alu_wb_data = '0;
        bus.mem_wb_valid = 1'b0; bus.mem_wb_addr = '0; bus.mem_wb_data = '0;
        mbusy = '0;
        cur = '0;
        @(negedge clk);
        do_reset();
        tbl[0]  = mk(0, 0, 12, 6, 1, 5, 64'hAA, 0, 0, 64'h0, 1, 0);
        tbl[1]  = mk(1, 12, 12, 6, 0, 0, 64'h0, 0, 0, 64'h0, 0, 0);
        tbl[2]  = mk(0, 0, 12, 6, 1, 1, 64'h11, 1, 2, 64'h22, 0, 1);
        tbl[3]  = mk(0, 0, 12, 6, 1, 3, 64'h33, 1, 4, 64'h44, 1, 0);
        tbl[4]  = mk(0, 0, 12, 6, 0, 0, 64'h0, 1, 6, 64'h66, 0, 1);
        tbl[5]  = mk(0, 0, 12, 6, 0, 0, 64'h0, 1, 8, 64'h88, 0, 1);
        tbl[6]  = mk(0, 0, 12, 6, 1, 9, 64'h99, 1, 10, 64'hA0, 1, 0);
        tbl[7]  = mk(0, 0, 12, 6, 1, 0, 64'h77, 0, 0, 64'h0, 1, 0);
        tbl[8]  = mk(0, 0, 12, 6, 1, 11, 64'hB1, 1, 12, 64'hC2, 0, 1);
        tbl[9]  = mk(0, 0, 12, 0, 0, 0, 64'h0, 1, 0, 64'h55, 0, 1);
        tbl[10] = mk(0, 0, 12, 0, 0, 0, 64'h0, 0, 0, 64'h0, 0, 0);
        for (int i = 0; i < 11; i++) cyc(tbl[i]);
        // Back-to-back ties straight out of reset alternate starting with ALU.
        do_reset();
        cyc(mk(0, 0, 0, 0, 1, 1, 64'h101, 1, 2, 64'h202, 1, 0));
        cyc(mk(0, 0, 0, 0, 1, 3, 64'h303, 1, 4, 64'h404, 0, 1));
        cyc(mk(0, 0, 0, 0, 1, 5, 64'h505, 1, 6, 64'h606, 1, 0));
        cyc(mk(0, 0, 0, 0, 1, 7, 64'h707, 1, 8, 64'h808, 0, 1));
        cyc(mk(0, 0, 0, 0, 0, 0, 64'h0, 0, 0, 64'h0, 0, 0));
        // r7 stays busy through its write cycle and reads free the cycle after.
        cyc(mk(1, 7, 7, 0, 0, 0, 64'h0, 0, 0, 64'h0, 0, 0));
        chk("r7_busy_after_issue", bus.rs1_busy, 1);
        cyc(mk(0, 0, 7, 0, 0, 0, 64'h0, 0, 0, 64'h0, 0, 0));
        cyc(mk(0, 0, 7, 0, 1, 7, 64'h70, 0, 0, 64'h0, 1, 0));
        chk("r7_busy_in_wb_cycle", bus.rs1_busy, 1);
        cyc(mk(0, 0, 7, 0, 0, 0, 64'h0, 0, 0, 64'h0, 0, 0));
        chk("r7_free_after_wb", bus.rs1_busy, 0);
        cyc(mk(0, 0, 7, 0, 0, 0, 64'h0, 0, 0, 64'h0, 0, 0));
        // Re-issue of r3 on the edge its write lands keeps it busy.
        cyc(mk(1, 3, 0, 3, 0, 0, 64'h0, 0, 0, 64'h0, 0, 0));
        cyc(mk(0, 0, 0, 3, 1, 3, 64'h3333, 0, 0, 64'h0, 1, 0));
        cyc(mk(1, 3, 0, 3, 0, 0, 64'h0, 0, 0, 64'h0, 0, 0));
        chk("r3_set_wins", bus.rs2_busy, 1);
        cyc(mk(0, 0, 0, 3, 0, 0, 64'h0, 1, 3, 64'h3030, 0, 1));
        cyc(mk(0, 0, 0, 3, 0, 0, 64'h0, 0, 0, 64'h0, 0, 0));
        chk("r3_free_after_second_wb", bus.rs2_busy, 0);
        // Reset right after a transfer drops the pending write, busy bits and grant history.
        cyc(mk(1, 9, 9, 0, 0, 0, 64'h0, 0, 0, 64'h0, 0, 0));
        cyc(mk(0, 0, 9, 0, 1, 9, 64'h99, 0, 0, 64'h0, 1, 0));
        do_reset();
        cyc(mk(0, 0, 9, 0, 0, 0, 64'h0, 0, 0, 64'h0, 0, 0));
        cyc(mk(0, 0, 9, 0, 1, 1, 64'h1, 1, 2, 64'h2, 1, 0));
        cyc(mk(0, 0, 9, 0, 0, 0, 64'h0, 0, 0, 64'h0, 0, 0));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
